s3g_tx_buf: RTL
===============

// Module: s3g_tx_buf
// PURPOSE
//  Parametrised S3G packet transmitter with an internal payload buffer of up to MAX_PAYLOAD bytes.
//  - Host logic writes payload bytes by address, then pulses packet_wr.
//  - Block drives uart_transceiver: START_BYTE, length, payload bytes, then Maxim CRC-8 of the payload.
//  - Replaces the fixed 3-byte s3g_tx; sits between the command decoder and the UART tx_data/tx_wr/tx_done port.
// PARAMETERS
//  MAX_PAYLOAD  32     buffer depth in bytes; largest legal payload_len
//  ADDR_W       5      buffer address width; 2**ADDR_W >= MAX_PAYLOAD
//  START_BYTE   8'hD5  packet start byte
// PORTS
//  clk          in   1       system clock
//  rst          in   1       synchronous active-high reset
//  wr_en        in   1       buffer write strobe, honoured only when busy=0
//  wr_addr      in   ADDR_W  buffer byte address; writes with wr_addr >= MAX_PAYLOAD are dropped
//  wr_data      in   8       buffer write data
//  payload_len  in   8       payload length, sampled on packet_wr
//  packet_wr    in   1       1-cycle send request
//  busy         out  1       high from accepted packet_wr until packet_sent
//  packet_sent  out  1       1-cycle pulse after the CRC byte's tx_done
//  len_err      out  1       1-cycle pulse: packet_wr with payload_len==0 or >MAX_PAYLOAD
//  tx_data      out  8       byte to UART, stable from tx_wr until tx_done
//  tx_wr        out  1       1-cycle UART write strobe
//  tx_done      in   1       UART byte-complete pulse
// BEHAVIOUR
//  - Reset values: busy=0, packet_sent=0, len_err=0, tx_wr=0, tx_data=0; FSM=IDLE, CRC=0.
//    Buffer RAM is not reset; contents persist across rst.
//  - FSM states: IDLE -> START -> LEN -> DATA -> CRC -> IDLE.
//    Each non-IDLE state issues one tx_wr on entry, then waits for tx_done.
//  - IDLE, packet_wr at cycle N with legal len:
//    - latch len, clear CRC, idx=0, busy=1 at N+1;
//    - tx_wr=1 with tx_data=START_BYTE at N+1.
//  - Illegal len: len_err=1 at N+1; no transmission; stays IDLE.
//  - tx_done at cycle M in a sending state -> next byte's tx_wr at M+1. Order:
//    - START_BYTE
//    - len
//    - buf[0..len-1]
//    - crc
//  - DATA: each payload byte b is folded into the CRC when issued.
//    CRC update: crc ^= b; then 8x { crc = crc[0] ? (crc>>1)^8'h8C : crc>>1 }.
//    Length and start bytes are excluded from the CRC.
//  - CRC state: tx_done at M -> packet_sent=1 and busy=0 at M+1; FSM returns to IDLE.
//    packet_wr at M+1 is accepted.
//  - Ignored inputs:
//    - packet_wr while busy is ignored; no len_err.
//    - tx_done in IDLE is ignored.
//    - wr_en while busy is ignored, so the buffer is frozen during transmission.
//  - tx_done in the same cycle as tx_wr is not possible from uart_transceiver. The block needs no handling for it.
//  - rst mid-packet: abort at next edge, outputs to reset values, no packet_sent. The partial UART byte is not recalled.
//  - idx counts 0..len-1 and never wraps past len.
// CONFIGURATION
//  S3G_TX_STATS_EN:
//  - Defined: adds output pkt_count [15:0]. Reset 0; +1 on each packet_sent; wraps 16'hFFFF -> 0.
//    Also adds output err_count [7:0]. Reset 0; +1 on each len_err; saturates at 8'hFF.
//  - Undefined: both ports and counters are absent; all other behaviour is identical.
// TESTING
//  - Basic: write buf[0]=8'h01, payload_len=1, packet_wr.
//    -> tx bytes D5,01,01,5E; one packet_sent; busy low after.
//  - CRC check vector: write ASCII "123456789" to buf[0..8], len=9.
//    -> bytes D5,09,31..39, then A1.
//  - Timing: bench returns tx_done 10 cycles after each tx_wr.
//    -> every tx_wr exactly 1 cycle after the previous tx_done; tx_data stable between them.
//  - Length errors: len=0 and then len=MAX_PAYLOAD+1 (33).
//    -> len_err pulse each time; no tx_wr; busy stays 0.
//  - Busy protection: during DATA, pulse packet_wr and write wr_en to buf[0]=FF.
//    -> both ignored; original payload and CRC sent.
//  - Reset mid-packet: assert rst during the DATA state, then send len=2 {AA,55}.
//    -> clean D5,02,AA,55,crc sequence; pkt_count=1 with S3G_TX_STATS_EN.

Source files
------------

// File: rtl/s3g_tx_buf_if.sv
// ============================================================================
// Module      : s3g_tx_buf_if
// Description : Host/UART signal bundle for the buffered S3G packet
//               transmitter.
//               master : host + UART side (drives writes, requests, tx_done)
//               slave  : s3g_tx_buf (drives status and UART byte stream)
//               Ports  : wr_en/wr_addr/wr_data  buffer write port
//                        payload_len/packet_wr  send request
//                        busy/packet_sent/len_err  status
//                        tx_data/tx_wr/tx_done  UART byte handshake
//               Macro S3G_TX_STATS_EN adds pkt_count/err_count.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface s3g_tx_buf_if #(
  parameter int ADDR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [7:0]        payload_len;
  logic              packet_wr;
  logic              busy;
  logic              packet_sent;
  logic              len_err;
  logic [7:0]        tx_data;
  logic              tx_wr;
  logic              tx_done;
`ifdef S3G_TX_STATS_EN
  logic [15:0]       pkt_count;
  logic [7:0]        err_count;

  modport master (
    output wr_en, wr_addr, wr_data, payload_len, packet_wr, tx_done,
    input  busy, packet_sent, len_err, tx_data, tx_wr, pkt_count, err_count
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, payload_len, packet_wr, tx_done,
    output busy, packet_sent, len_err, tx_data, tx_wr, pkt_count, err_count
  );
`else
  modport master (
    output wr_en, wr_addr, wr_data, payload_len, packet_wr, tx_done,
    input  busy, packet_sent, len_err, tx_data, tx_wr
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, payload_len, packet_wr, tx_done,
    output busy, packet_sent, len_err, tx_data, tx_wr
  );
`endif
endinterface

`default_nettype wire

// File: rtl/s3g_tx_buf.sv
// ============================================================================
// Module      : s3g_tx_buf
// Description : Buffered S3G packet transmitter. Host writes payload bytes
//               into an internal buffer, then pulses packet_wr; the block
//               sends START_BYTE, length, payload and Maxim CRC-8 of the
//               payload to the UART, one byte per tx_wr/tx_done handshake.
//               Ports  : clk, rst (sync, active high), bus (slave modport of
//                        s3g_tx_buf_if: buffer write, send request, status,
//                        UART tx_data/tx_wr/tx_done).
//               Macro S3G_TX_STATS_EN adds pkt_count (wrapping) and
//               err_count (saturating) statistics outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module s3g_tx_buf #(
  parameter int         MAX_PAYLOAD = 32,
  parameter int         ADDR_W      = 5,
  parameter logic [7:0] START_BYTE  = 8'hD5
) (
  input  wire logic   clk,
  input  wire logic   rst,
  s3g_tx_buf_if.slave bus
);

  localparam logic [7:0]    MAX_LEN_C = 8'(MAX_PAYLOAD);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_LEN   = 3'd2,
    S_DATA  = 3'd3,
    S_CRC   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] crc_q, crc_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       busy_q, busy_d;
  logic       sent_q, sent_d;
  logic       len_err_q, len_err_d;
  logic       tx_wr_q, tx_wr_d;

  logic [7:0] mem [0:MAX_PAYLOAD-1];
  logic [7:0] rd_idx;
  logic [7:0] rd_byte;
  logic       len_ok;

  // Maxim/Dallas CRC-8, reflected polynomial 0x8C, one byte per call.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in,
                                           input logic [7:0] b);
    logic [7:0] c;
    c = crc_in ^ b;
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    end
    return c;
  endfunction

  // Buffer is frozen while a packet is in flight so the CRC matches the bytes.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy_q && ({1'b0, bus.wr_addr} < DEPTH_C)) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Byte to be issued on the next tx_done: buf[0] when leaving LEN,
  // buf[idx+1] when advancing inside DATA.
  always_comb begin
    rd_idx = 8'd0;
    if (state_q == S_DATA) begin
      rd_idx = idx_q + 8'd1;
    end
  end

  assign rd_byte = mem[rd_idx[ADDR_W-1:0]];
  assign len_ok  = (bus.payload_len != 8'd0) && (bus.payload_len <= MAX_LEN_C);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    crc_d     = crc_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;
    busy_d    = busy_q;
    sent_d    = 1'b0;
    len_err_d = 1'b0;
    tx_wr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.packet_wr) begin
          if (len_ok) begin
            state_d   = S_START;
            len_d     = bus.payload_len;
            crc_d     = 8'd0;
            idx_d     = 8'd0;
            busy_d    = 1'b1;
            tx_wr_d   = 1'b1;
            tx_data_d = START_BYTE;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      S_START: begin
        if (bus.tx_done) begin
          state_d   = S_LEN;
          tx_wr_d   = 1'b1;
          tx_data_d = len_q;
        end
      end
      S_LEN: begin
        if (bus.tx_done) begin
          state_d   = S_DATA;
          tx_wr_d   = 1'b1;
          tx_data_d = rd_byte;
          crc_d     = crc8_byte(crc_q, rd_byte);
        end
      end
      S_DATA: begin
        if (bus.tx_done) begin
          tx_wr_d = 1'b1;
          if (idx_q == len_q - 8'd1) begin
            // CRC register already holds every payload byte.
            state_d   = S_CRC;
            tx_data_d = crc_q;
          end else begin
            idx_d     = idx_q + 8'd1;
            tx_data_d = rd_byte;
            crc_d     = crc8_byte(crc_q, rd_byte);
          end
        end
      end
      S_CRC: begin
        if (bus.tx_done) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          sent_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= 8'd0;
      crc_q     <= 8'd0;
      idx_q     <= 8'd0;
      tx_data_q <= 8'd0;
      busy_q    <= 1'b0;
      sent_q    <= 1'b0;
      len_err_q <= 1'b0;
      tx_wr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      crc_q     <= crc_d;
      idx_q     <= idx_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
      sent_q    <= sent_d;
      len_err_q <= len_err_d;
      tx_wr_q   <= tx_wr_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.packet_sent = sent_q;
  assign bus.len_err     = len_err_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_wr       = tx_wr_q;

`ifdef S3G_TX_STATS_EN
  logic [15:0] pkt_count_q;
  logic [7:0]  err_count_q;

  // Counters step together with the packet_sent / len_err pulses they count.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count_q <= 16'd0;
      err_count_q <= 8'd0;
    end else begin
      if (sent_d) begin
        pkt_count_q <= pkt_count_q + 16'd1;
      end
      if (len_err_d && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign bus.pkt_count = pkt_count_q;
  assign bus.err_count = err_count_q;
`endif

endmodule

`default_nettype wire
